// File: rtl/proc_ctrl_pkg.sv
// Shared types and default constants for the processor run sequencer.
// TopLevel and benches pick up the same defaults from here.
package proc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } run_state_t;

  localparam int unsigned CYC_W_DEF    = 16;
  localparam int unsigned INIT_CYC_DEF = 2;
  localparam int unsigned TIMEOUT_DEF  = 1000;

endpackage

// File: rtl/proc_run_ctrl.sv
// Run sequencer: start edge -> timed init pulse -> gated run phase, ended by
// core halt, host abort or the cycle watchdog.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned CYC_W    = CYC_W_DEF,
  parameter int unsigned INIT_CYC = INIT_CYC_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             start,
  input  logic             abort,
  input  logic             core_halt,
  output logic             core_init,
  output logic             core_run,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int unsigned IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYC - 1);
  localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(TIMEOUT - 1);

  run_state_t       state_q, state_d;
  logic             start_q;
  logic             start_rise;
  logic [IW-1:0]    init_cnt;
  logic             enter_init;

  assign start_rise = start & ~start_q;
  assign enter_init = (state_d == INIT) && (state_q != INIT);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
    end
  end

  // abort is checked first in every state so it beats start, halt and timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (abort)           state_d = IDLE;
        else if (start_rise) state_d = INIT;
      end
      INIT: begin
        if (abort)                       state_d = IDLE;
        else if (init_cnt == INIT_LAST)  state_d = RUN;
      end
      RUN: begin
        if (abort)                       state_d = IDLE;
        else if (core_halt)              state_d = DONE;
        else if (cycle_count == RUN_LAST) state_d = FAULT;
      end
      DONE, FAULT: begin
        if (abort)           state_d = IDLE;
        else if (start_rise) state_d = INIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      init_cnt <= '0;
    end else if (enter_init) begin
      init_cnt <= '0;
    end else if (state_q == INIT && state_d == INIT) begin
      init_cnt <= init_cnt + 1'b1;
    end
  end

  // Counts every RUN cycle, including the exit cycle; RUN is left no later
  // than count TIMEOUT-1, so the value tops out at TIMEOUT and never wraps.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cycle_count <= '0;
    end else if (enter_init) begin
      cycle_count <= '0;
    end else if (state_q == RUN) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  assign core_init = (state_q == INIT);
  assign core_run  = (state_q == RUN);
  assign busy      = (state_q == INIT) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign timeout   = (state_q == FAULT);

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: each run's outcome is predicted from the
// halt/abort/timeout schedule and checked when the DUT drops busy.
module tb_proc_run_ctrl;

  localparam int CYC_W    = 16;
  localparam int INIT_CYC = 2;
  localparam int TIMEOUT  = 50;

  localparam logic [1:0] K_ABORT = 2'b00;
  localparam logic [1:0] K_FAULT = 2'b01;
  localparam logic [1:0] K_DONE  = 2'b10;

  typedef struct {
    logic [1:0] kind;
    int         count;
    int         init_len;
    int         end_cyc;
  } exp_t;

  logic             CLK;
  logic             RESETn;
  logic             start;
  logic             abort;
  logic             core_halt;
  logic             core_init;
  logic             core_run;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CYC_W-1:0] cycle_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t expq[$];

  proc_run_ctrl #(
    .CYC_W   (CYC_W),
    .INIT_CYC(INIT_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .start      (start),
    .abort      (abort),
    .core_halt  (core_halt),
    .core_init  (core_init),
    .core_run   (core_run),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic prev_busy = 1'b0;
  int   init_len  = 0;
  int   run_len   = 0;
  exp_t me;

  always @(negedge CLK) begin
    if (!RESETn) begin
      prev_busy = 1'b0;
      init_len  = 0;
      run_len   = 0;
    end else begin
      chk("busy_decode", {31'd0, busy}, {31'd0, core_init | core_run});
      chk("init_run_excl", {31'd0, core_init & core_run}, 32'd0);
      chk("status_onehot", 32'(busy) + 32'(done) + 32'(timeout) <= 32'd1, 32'd1);
      if (!prev_busy && busy) begin
        chk("run_expected", expq.size() > 0, 32'd1);
        chk("first_busy_is_init", {31'd0, core_init}, 32'd1);
        chk("count_cleared", 32'(cycle_count), 32'd0);
        init_len = 0;
        run_len  = 0;
      end
      if (core_init) init_len++;
      if (core_run) begin
        run_len++;
        chk("count_tracks_run", 32'(cycle_count), 32'(run_len - 1));
      end
      if (prev_busy && !busy) begin
        if (expq.size() == 0) begin
          chk("end_expected", 32'd0, 32'd1);
        end else begin
          me = expq.pop_front();
          chk("end_kind", {30'd0, done, timeout}, {30'd0, me.kind});
          chk("end_count", 32'(cycle_count), 32'(me.count));
          chk("run_len", 32'(run_len), 32'(me.count));
          chk("init_len", 32'(init_len), 32'(me.init_len));
          chk("end_cycle", 32'(cyc), 32'(me.end_cyc));
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------- driver ----------------
  // halt_at/abort_at are RUN-cycle numbers (0 = never); init_abort aborts in
  // the first INIT cycle; repulse issues extra start edges inside INIT/RUN.
  task automatic run_one(input int halt_at, input int abort_at, input int hold_start,
                         input bit stale, input bit init_abort, input bit repulse);
    exp_t e;
    int   k, len, total;
    k = cyc;
    if (init_abort) begin
      e.kind = K_ABORT; len = 0; total = 1;
      e.init_len = 1; e.end_cyc = k + 2;
    end else begin
      len = TIMEOUT; e.kind = K_FAULT;
      if (halt_at > 0 && halt_at <= len)   begin len = halt_at;  e.kind = K_DONE;  end
      if (abort_at > 0 && abort_at <= len) begin len = abort_at; e.kind = K_ABORT; end
      total = INIT_CYC + len;
      e.init_len = INIT_CYC; e.end_cyc = k + INIT_CYC + 1 + len;
    end
    e.count = len;
    expq.push_back(e);
    for (int j = 0; j <= total; j++) begin
      start     = (j < hold_start) || (repulse && j >= 2 && j <= total && (j == 2 || j == INIT_CYC + 3));
      core_halt = (stale && j <= INIT_CYC) || (!init_abort && halt_at > 0 && j == INIT_CYC + halt_at);
      abort     = init_abort ? (j == 1) : (abort_at > 0 && j == INIT_CYC + abort_at);
      tick();
    end
    core_halt = 1'b0;
    abort     = 1'b0;
    for (int j = total + 1; j < hold_start; j++) begin
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    tick();
  endtask

  initial begin
    RESETn = 1'b0; start = 1'b0; abort = 1'b0; core_halt = 1'b0;

    // reset held with start toggling
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      tick();
      chk("rst_outputs", {27'd0, core_init, core_run, busy, done, timeout}, 32'd0);
      chk("rst_count", 32'(cycle_count), 32'd0);
    end
    start  = 1'b0;
    RESETn = 1'b1;
    tick(); tick();
    chk("idle_after_rst", {27'd0, core_init, core_run, busy, done, timeout}, 32'd0);

    // halt on 20th RUN cycle
    run_one(20, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk("t2_count", 32'(cycle_count), 32'd20);

    // watchdog expiry
    run_one(0, 0, 1, 1'b0, 1'b0, 1'b1);
    chk("t3_timeout", {31'd0, timeout}, 32'd1);
    chk("t3_core_run", {31'd0, core_run}, 32'd0);
    chk("t3_count", 32'(cycle_count), 32'(TIMEOUT));

    // stale halt through INIT, real halt in 1st RUN cycle (restart from FAULT)
    run_one(1, 0, 1, 1'b1, 1'b0, 1'b0);
    chk("t4_count", 32'(cycle_count), 32'd1);

    // held start, abort at RUN cycle 7
    run_one(0, 7, 30, 1'b0, 1'b0, 1'b0);
    chk("t5_count_frozen", 32'(cycle_count), 32'd7);
    start = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_abort_beats_start", {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    tick();

    // halt coincides with timeout, then restart from DONE
    run_one(TIMEOUT, 0, 1, 1'b0, 1'b0, 1'b0);
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_timeout", {31'd0, timeout}, 32'd0);
    chk("t6_count", 32'(cycle_count), 32'(TIMEOUT));
    run_one(3, 0, 2, 1'b0, 1'b0, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_from_done", {31'd0, done}, 32'd0);
    chk("abort_keeps_count", 32'(cycle_count), 32'd3);

    // abort and halt in the same RUN cycle; abort during INIT
    run_one(5, 5, 1, 1'b0, 1'b0, 1'b0);
    run_one(0, 0, 1, 1'b0, 1'b1, 1'b0);
    chk("init_abort_count", 32'(cycle_count), 32'd0);

    // asynchronous reset in the middle of RUN
    begin
      exp_t d;
      d.kind = K_ABORT; d.count = 0; d.init_len = 0; d.end_cyc = 0;
      expq.push_back(d);
      start = 1'b1; tick(); start = 1'b0;
      repeat (INIT_CYC + 5) tick();
      chk("pre_rst_running", {31'd0, core_run}, 32'd1);
      RESETn = 1'b0;
      #1;
      chk("async_rst_run", {31'd0, core_run}, 32'd0);
      chk("async_rst_init", {31'd0, core_init}, 32'd0);
      chk("async_rst_count", 32'(cycle_count), 32'd0);
      expq.delete();
      tick(); tick();
      RESETn = 1'b1;
      tick();
    end

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      int h, a, hs;
      bit st, ia, rp;
      h  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TIMEOUT + 5);
      a  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT) : 0;
      hs = $urandom_range(1, 6);
      st = $urandom_range(0, 1);
      ia = ($urandom_range(0, 9) == 0);
      rp = $urandom_range(0, 1);
      run_one(h, a, hs, st, ia, rp);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (4) tick();
    chk("queue_drained", expq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
